// File: rtl/shared_timer_pkg.sv
// Shared definitions for the shared interval timer arbiter: FSM states and id-width helper.
package shared_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interval_counter.sv
// Up-counter with synchronous clear (priority) and increment-on-enable.
module interval_counter #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    output logic [NUM_BITS-1:0] value
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            value <= '0;
        end else if (enable) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/shared_timer_arbiter.sv
// Round-robin arbiter granting one shared interval counter to NUM_REQ requesters.
// Optional feature: define SHARED_TIMER_ABORT_EN to add the abort input and aborted pulse.
module shared_timer_arbiter
    import shared_timer_pkg::*;
#(
    parameter int  NUM_BITS = 4,
    parameter int  NUM_REQ  = 4,
    localparam int ID_W     = id_width(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
`ifdef SHARED_TIMER_ABORT_EN
    input  logic                         abort,
    output logic                         aborted,
`endif
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*NUM_BITS-1:0]  len,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    output logic [NUM_BITS-1:0]          value,
    output logic                         done,
    output logic [ID_W-1:0]              done_id
);

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     last_winner;
    logic [ID_W-1:0]     rr_winner;
    logic [NUM_BITS-1:0] rr_len;
    logic [NUM_BITS-1:0] len_q;
    logic                rr_found;
    int                  rr_dist;
    int                  rr_best;
    logic                cnt_clear;
    logic                cnt_enable;

    // Round-robin: the requester with the smallest positive distance above last_winner wins.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        rr_len    = '0;
        rr_dist   = 0;
        rr_best   = NUM_REQ + 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                rr_dist = (i > int'(last_winner)) ? i - int'(last_winner)
                                                  : i - int'(last_winner) + NUM_REQ;
                if (rr_dist < rr_best) begin
                    rr_best   = rr_dist;
                    rr_found  = 1'b1;
                    rr_winner = ID_W'(i);
                    rr_len    = len[i*NUM_BITS +: NUM_BITS];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (rr_found) state_next = COUNT;
            COUNT: begin
`ifdef SHARED_TIMER_ABORT_EN
                if (abort) begin
                    state_next = IDLE;
                end else if (value == len_q) begin
                    state_next = DONE;
                end
`else
                if (value == len_q) begin
                    state_next = DONE;
                end
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Winner and its length are captured at arbitration; later req/len changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= ID_W'(NUM_REQ - 1);
        end else if (state == IDLE && rr_found) begin
            last_winner <= rr_winner;
        end
    end

    // NOTE: len_q is plain datapath, only read in COUNT after being loaded, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && rr_found) begin
            len_q <= rr_len;
        end
    end

`ifdef SHARED_TIMER_ABORT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            aborted <= 1'b0;
        end else begin
            aborted <= (state == COUNT) && abort;
        end
    end
`endif

    // Clearing on any exit from COUNT keeps value at 0 in DONE and IDLE.
    assign cnt_clear  = (state_next != COUNT);
    assign cnt_enable = (state == COUNT);

    interval_counter #(
        .NUM_BITS (NUM_BITS)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .value  (value)
    );

    always_comb begin
        grant   = '0;
        busy    = 1'b0;
        done    = 1'b0;
        done_id = '0;
        case (state)
            COUNT: begin
                grant = NUM_REQ'(1) << last_winner;
                busy  = 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                done_id = last_winner;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Scoreboard bench for shared_timer_arbiter: transaction-level model feeds an expectation queue,
// a negedge monitor compares every cycle and retires entries on done.
module tb_shared_timer_arbiter;

    localparam int NB  = 4;
    localparam int NR  = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              abort = 1'b0;
    logic              aborted;
    logic [NR-1:0]     req;
    logic [NR*NB-1:0]  len;
    logic [NR-1:0]     grant;
    logic              busy;
    logic [NB-1:0]     value;
    logic              done;
    logic [IDW-1:0]    done_id;

    shared_timer_arbiter #(
        .NUM_BITS (NB),
        .NUM_REQ  (NR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef SHARED_TIMER_ABORT_EN
        .abort   (abort),
        .aborted (aborted),
`endif
        .req     (req),
        .len     (len),
        .grant   (grant),
        .busy    (busy),
        .value   (value),
        .done    (done),
        .done_id (done_id)
    );

`ifndef SHARED_TIMER_ABORT_EN
    assign aborted = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int ln;
        int gcyc;
    } exp_t;

    exp_t exp_q[$];
    int   ab_q[$];
    int   done_log[$];
    int   done_cyc_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on        = 1'b0;
    bit flush_pending = 1'b0;
    bit abort_pending = 1'b0;
    int last_w   = NR - 1;
    int next_arb = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    // Reference model: one step drives the inputs for the current cycle and predicts arbitration.
    task automatic step(input logic [NR-1:0] r, input logic [NR*NB-1:0] l, input logic rs,
                        input logic ab);
        exp_t e;
        int   w;
        @(posedge clk);
        #1;
        if (flush_pending) begin
            exp_q.delete();
            ab_q.delete();
            last_w        = NR - 1;
            next_arb      = cyc;
            flush_pending = 1'b0;
            abort_pending = 1'b0;
        end
        if (abort_pending) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            ab_q.push_back(cyc);
            next_arb      = cyc;
            abort_pending = 1'b0;
        end
        req   = r;
        len   = l;
        reset = rs;
        abort = ab;
        if (rs) begin
            flush_pending = 1'b1;
        end else begin
`ifdef SHARED_TIMER_ABORT_EN
            if (ab && exp_q.size() > 0 && cyc >= exp_q[0].gcyc &&
                cyc <= exp_q[0].gcyc + exp_q[0].ln)
                abort_pending = 1'b1;
`endif
            if (cyc >= next_arb && r != '0) begin
                w = -1;
                for (int k = 1; k <= NR && w < 0; k++) begin
                    if (r[(last_w + k) % NR]) w = (last_w + k) % NR;
                end
                e.id   = w;
                e.ln   = int'(l[w*NB +: NB]);
                e.gcyc = cyc + 1;
                exp_q.push_back(e);
                last_w   = w;
                next_arb = cyc + 3 + e.ln;
            end
        end
    endtask

    always @(negedge clk) begin
        logic [NR-1:0] eg;
        int  ev;
        int  k;
        int  eid;
        bit  eb;
        bit  ed;
        bit  ea;
        if (mon_on) begin
            eg = '0; ev = 0; eb = 1'b0; ed = 1'b0; eid = 0;
            if (exp_q.size() > 0 && cyc >= exp_q[0].gcyc) begin
                k = cyc - exp_q[0].gcyc;
                if (k <= exp_q[0].ln) begin
                    eg = NR'(1) << exp_q[0].id;
                    eb = 1'b1;
                    ev = k;
                end else begin
                    ed  = 1'b1;
                    eid = exp_q[0].id;
                end
            end
            check("grant", 32'(grant), 32'(eg));
            check("busy",  32'(busy),  32'(eb));
            check("value", 32'(value), ev);
            check("done",  32'(done),  32'(ed));
            if (ed) check("done_id", 32'(done_id), eid);
            if (done === 1'b1) begin
                done_log.push_back(int'(done_id));
                done_cyc_log.push_back(cyc);
            end
            if (ed) void'(exp_q.pop_front());
            ea = (ab_q.size() > 0) && (ab_q[0] == cyc);
            check("aborted", 32'(aborted), 32'(ea));
            if (ea) void'(ab_q.pop_front());
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int arb_c;
        int base;
        int ids[5];
        logic [NR-1:0]    r;
        logic [NR*NB-1:0] l;
        ids = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        req   = '0;
        len   = '0;
        for (int i = 0; i < 3; i++) step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        mon_on = 1'b1;
        idle(2);

        // Single requester, len 3: done five cycles after the sampled request.
        step(4'b0001, 16'h0003, 1'b0, 1'b0);
        arb_c = cyc;
        idle(6);
        check("latency_len3", done_cyc_log[$] - arb_c, 5);
        check("done_id_len3", done_log[$], 0);

        // All requesting with zero length: rotation 0,1,2,3,0 three cycles apart.
        do_reset();
        base = done_log.size();
        for (int i = 0; i < 13; i++) step(4'b1111, '0, 1'b0, 1'b0);
        idle(4);
        check("rr_count", done_log.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            if (done_log.size() > base + i) begin
                check("rr_order", done_log[base + i], ids[i]);
                if (i > 0) check("rr_spacing", done_cyc_log[base+i] - done_cyc_log[base+i-1], 3);
            end
        end

        // Full-scale length: counts 0..15 without wrapping.
        step(4'b0001, 16'h000F, 1'b0, 1'b0);
        arb_c = cyc;
        idle(18);
        check("latency_len15", done_cyc_log[$] - arb_c, 17);

        // req and len change mid-count; the latched length of 5 still applies.
        step(4'b0001, 16'h0005, 1'b0, 1'b0);
        arb_c = cyc;
        step(4'b0000, 16'h0001, 1'b0, 1'b0);
        idle(8);
        check("latency_latched", done_cyc_log[$] - arb_c, 7);

        // Reset at value 2 of a length-6 interval; next grant goes to requester 0.
        base = done_log.size();
        step(4'b0010, 16'h0060, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        step(4'b1111, '0, 1'b1, 1'b0);
        step(4'b1111, '0, 1'b0, 1'b0);
        idle(4);
        check("reset_done_count", done_log.size() - base, 1);
        check("reset_next_winner", done_log[$], 0);

`ifdef SHARED_TIMER_ABORT_EN
        // Abort on the final count cycle wins over completion.
        base = done_log.size();
        step(4'b0001, 16'h0003, 1'b0, 1'b0);
        idle(3);
        step('0, '0, 1'b0, 1'b1);
        idle(5);
        check("abort_no_done", done_log.size() - base, 0);
`endif

        // Randomised traffic with occasional reset and abort.
        for (int i = 0; i < 3000; i++) begin
            r = NR'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = '0;
            l = (NR*NB)'($urandom);
            step(r, l, ($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0));
        end
        idle(20);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
